// File: rtl/fetch_unit_pkg.sv
// Shared Y86 fetch definitions: icodes, status codes, run state
// and the icode -> instruction shape decode.
package fetch_unit_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {
    RUN,
    STOPPED
  } run_t;

  typedef struct packed {
    logic regids;
    logic valc;
    logic valid;
  } need_t;

  function automatic need_t inst_need(input logic [3:0] icode);
    need_t n;
    n.regids = 1'b0;
    n.valc   = 1'b0;
    n.valid  = 1'b1;
    unique case (icode)
      IHALT, INOP, IRET: ;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:
        n.regids = 1'b1;
      IJXX, ICALL:
        n.valc = 1'b1;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        n.regids = 1'b1;
        n.valc   = 1'b1;
      end
      default:
        n.valid = 1'b0;
    endcase
    return n;
  endfunction

  // Invalid icodes carry neither field, so they come out as length 1.
  function automatic logic [3:0] inst_len(input need_t n);
    return 4'd1 + {3'd0, n.regids} + {n.valc, 3'd0};
  endfunction

endpackage

// File: rtl/fetch_byte_queue.sv
// Circular instruction byte buffer: FETCH_BYTES-wide push,
// 0..10 byte pop, 10-byte head window for the decoder.
module fetch_byte_queue #(
  parameter  int FETCH_BYTES = 4,
  parameter  int BUF_BYTES   = 16,
  localparam int CW = $clog2(BUF_BYTES + 1),
  localparam int PW = $clog2(BUF_BYTES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [8*FETCH_BYTES-1:0] push_data,
  input  logic                     pop,
  input  logic [3:0]               pop_len,
  output logic [CW-1:0]            count,
  output logic [79:0]              head
);

  logic [7:0]    mem [BUF_BYTES];
  logic [PW-1:0] hd;
  logic [PW-1:0] tl;
  logic [CW-1:0] cnt;

  // Offsets never exceed BUF_BYTES, so one subtraction wraps.
  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input int            off
  );
    int s;
    s = int'(p) + off;
    if (s >= BUF_BYTES) s = s - BUF_BYTES;
    return PW'(s);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
      for (int i = 0; i < BUF_BYTES; i++)
        mem[i] <= '0;
    end else if (flush) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < FETCH_BYTES; i++)
          mem[wrap(tl, i)] <= push_data[8*i +: 8];
        tl <= wrap(tl, FETCH_BYTES);
      end
      if (pop)
        hd <= wrap(hd, int'(pop_len));
      cnt <= cnt
           + (push ? CW'(FETCH_BYTES) : '0)
           - (pop  ? CW'(pop_len)     : '0);
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < 10; i++)
      head[8*i +: 8] = mem[wrap(hd, i)];
  end

  assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Y86 fetch stage: owns the PC, prefetches into a byte queue and
// hands one decoded instruction per handshake to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int FETCH_BYTES = 4,
  parameter int BUF_BYTES   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req_o,
  output logic [PC_W-1:0]          imem_addr_o,
  input  logic                     imem_rvalid_i,
  input  logic [8*FETCH_BYTES-1:0] imem_rdata_i,
  input  logic                     imem_err_i,
  input  logic                     redirect_i,
  input  logic [PC_W-1:0]          redirect_pc_i,
  output logic                     inst_valid_o,
  input  logic                     inst_ready_i,
  output logic [3:0]               icode_o,
  output logic [3:0]               ifun_o,
  output logic [3:0]               rA_o,
  output logic [3:0]               rB_o,
  output logic [63:0]              valC_o,
  output logic [PC_W-1:0]          valP_o,
  output logic [PC_W-1:0]          pc_o,
  output logic [PC_W-1:0]          pred_pc_o,
  output logic [2:0]               stat_o
);

  localparam int CW = $clog2(BUF_BYTES + 1);
  localparam logic [CW-1:0] REQ_MAX =
    CW'(BUF_BYTES - FETCH_BYTES);

  if (BUF_BYTES < 10 + FETCH_BYTES) begin : g_buf_chk
    $error("BUF_BYTES must be >= 10 + FETCH_BYTES");
  end
  if (FETCH_BYTES < 1 || FETCH_BYTES > 8 ||
      (FETCH_BYTES & (FETCH_BYTES - 1)) != 0) begin : g_fb_chk
    $error("FETCH_BYTES must be a power of 2 in 1..8");
  end
  if (PC_W < 1 || PC_W > 64) begin : g_pc_chk
    $error("PC_W must be in 1..64");
  end

  run_t            state;
  run_t            state_next;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] head_pc;
  logic            pend;
  logic            drop;
  logic            err;
  logic            live;

  logic [CW-1:0]   count;
  logic [79:0]     win;

  logic [3:0]      icode;
  logic [3:0]      len;
  need_t           need;
  logic            have;
  logic            adr;
  logic            valid;
  logic            cti;
  logic [63:0]     valc;
  logic [PC_W-1:0] valp;
  logic [PC_W-1:0] pred;

  logic            xfer;
  logic            taken;
  logic            stop;
  logic            flush;
  logic            req;
  logic            rsp_take;
  logic            push;
  logic [PC_W-1:0] new_pc;

  always_comb begin
    icode = win[7:4];
    need  = inst_need(icode);
    len   = inst_len(need);
    have  = count >= CW'(len);
    adr   = err & ~have;
    valid = (state == RUN) & ~redirect_i & (have | err);
    cti   = (icode == IJXX) | (icode == ICALL);
    valp  = head_pc + PC_W'(len);
    valc  = '0;
    if (need.valc)
      valc = need.regids ? win[79:16] : win[71:8];
    pred  = cti ? valc[PC_W-1:0] : valp;
  end

  assign xfer  = valid & inst_ready_i;
  assign taken = xfer & ~adr & cti & (pred != valp);
  assign stop  = xfer & (adr | ~need.valid |
                         (icode == IRET) | (icode == IHALT));
  assign flush = redirect_i | taken;
  assign new_pc = redirect_i ? redirect_pc_i : pred;

  // A response is ours only if a live request is waiting on it.
  assign rsp_take = imem_rvalid_i & ~drop & pend;
  assign push     = rsp_take & ~imem_err_i & ~flush;
  assign req      = live & (state == RUN) & ~pend & ~err &
                    (count <= REQ_MAX) & ~flush & ~stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= '0;
      head_pc  <= '0;
      pend     <= 1'b0;
      drop     <= 1'b0;
      err      <= 1'b0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      if (flush) begin
        fetch_pc <= new_pc;
        head_pc  <= new_pc;
        pend     <= 1'b0;
        err      <= 1'b0;
        drop     <= (drop & ~imem_rvalid_i) | (pend & ~rsp_take);
      end else begin
        if (req) begin
          fetch_pc <= fetch_pc + PC_W'(FETCH_BYTES);
          pend     <= 1'b1;
        end
        if (rsp_take) begin
          pend <= 1'b0;
          if (imem_err_i) err <= 1'b1;
        end
        if (imem_rvalid_i & drop)
          drop <= 1'b0;
        if (xfer & ~adr)
          head_pc <= valp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (redirect_i)
      state_next = RUN;
    else if (stop)
      state_next = STOPPED;
  end

  fetch_byte_queue #(
    .FETCH_BYTES(FETCH_BYTES),
    .BUF_BYTES  (BUF_BYTES)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .push_data(imem_rdata_i),
    .pop      (xfer),
    .pop_len  (adr ? 4'd0 : len),
    .count    (count),
    .head     (win)
  );

  assign imem_req_o   = req;
  assign imem_addr_o  = fetch_pc;
  assign inst_valid_o = valid;

  always_comb begin
    icode_o   = '0;
    ifun_o    = '0;
    rA_o      = '0;
    rB_o      = '0;
    valC_o    = '0;
    valP_o    = '0;
    pc_o      = '0;
    pred_pc_o = '0;
    stat_o    = SAOK;
    if (valid) begin
      pc_o = head_pc;
      if (adr) begin
        rA_o      = RNONE;
        rB_o      = RNONE;
        valP_o    = head_pc;
        pred_pc_o = head_pc;
        stat_o    = SADR;
      end else begin
        icode_o   = icode;
        ifun_o    = win[3:0];
        rA_o      = need.regids ? win[15:12] : RNONE;
        rB_o      = need.regids ? win[11:8]  : RNONE;
        valC_o    = valc;
        valP_o    = valp;
        pred_pc_o = pred;
        if (icode == IHALT)   stat_o = SHLT;
        else if (!need.valid) stat_o = SINS;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable
// in-order instruction memory model.
module tb_fetch_unit;

  localparam int PC_W = 32;
  localparam int FB   = 4;

  logic            clk;
  logic            rst_n;
  logic            imem_req_o;
  logic [PC_W-1:0] imem_addr_o;
  logic            imem_rvalid_i;
  logic [8*FB-1:0] imem_rdata_i;
  logic            imem_err_i;
  logic            redirect_i;
  logic [PC_W-1:0] redirect_pc_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [3:0]      icode_o;
  logic [3:0]      ifun_o;
  logic [3:0]      rA_o;
  logic [3:0]      rB_o;
  logic [63:0]     valC_o;
  logic [PC_W-1:0] valP_o;
  logic [PC_W-1:0] pc_o;
  logic [PC_W-1:0] pred_pc_o;
  logic [2:0]      stat_o;

  fetch_unit #(.PC_W(PC_W), .FETCH_BYTES(FB), .BUF_BYTES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .imem_err_i   (imem_err_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .icode_o      (icode_o),
    .ifun_o       (ifun_o),
    .rA_o         (rA_o),
    .rB_o         (rB_o),
    .valC_o       (valC_o),
    .valP_o       (valP_o),
    .pc_o         (pc_o),
    .pred_pc_o    (pred_pc_o),
    .stat_o       (stat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  int          lat;
  bit          err_en;
  logic [31:0] err_addr;
  logic [31:0] pq_addr [$];
  int          pq_due [$];
  logic [31:0] req_log [$];
  int          cyc;
  int          last_due;
  int          pass_cnt;
  int          total_cnt;

  // Memory model: samples 1 time unit after the falling edge,
  // answers in order once each request's due cycle is reached.
  initial begin
    logic [31:0] a;
    int d;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    imem_err_i    = 1'b0;
    cyc      = 0;
    last_due = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      imem_rvalid_i = 1'b0;
      imem_err_i    = 1'b0;
      if (!rst_n) begin
        pq_addr.delete();
        pq_due.delete();
      end else begin
        if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
          a = pq_addr.pop_front();
          void'(pq_due.pop_front());
          imem_rvalid_i = 1'b1;
          for (int k = 0; k < FB; k++)
            imem_rdata_i[8*k +: 8] = mem[8'(a + 32'(k))];
          imem_err_i = err_en && (a == err_addr);
        end
        if (imem_req_o === 1'b1) begin
          d = cyc + lat;
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          pq_addr.push_back(imem_addr_o);
          pq_due.push_back(d);
          req_log.push_back(imem_addr_o);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic fill(input logic [7:0] b);
    for (int i = 0; i < 256; i++) mem[i] = b;
  endtask

  task automatic hold_reset;
    @(negedge clk);
    rst_n         = 1'b0;
    inst_ready_i  = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    repeat (2) @(negedge clk);
    req_log.delete();
  endtask

  task automatic restart;
    hold_reset();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (inst_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept;
    inst_ready_i = 1'b1;
    req_log.delete();
    @(negedge clk);
    inst_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [175:0] dat;
    fill(8'h10);
    lat = 1;
    err_en = 1'b0;
    hold_reset();
    dat = {icode_o, ifun_o, rA_o, rB_o, valC_o,
           valP_o, pc_o, pred_pc_o};
    total_cnt++;
    if ({imem_req_o, inst_valid_o} !== 2'b00)
      $display("FAIL reset_ctrl: got %b, want 00",
               {imem_req_o, inst_valid_o});
    else pass_cnt++;
    total_cnt++;
    if (dat !== '0)
      $display("FAIL reset_data: got %h, want 0", dat);
    else pass_cnt++;
    total_cnt++;
    if (stat_o !== 3'd1)
      $display("FAIL reset_stat: got %0d, want 1", stat_o);
    else pass_cnt++;
    total_cnt++;
    if (imem_addr_o !== 32'h0)
      $display("FAIL reset_addr: got %h, want 0", imem_addr_o);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_irmovq;
    bit ok;
    logic [7:0] prog [12];
    prog = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00};
    fill(8'h10);
    for (int i = 0; i < 12; i++) mem[i] = prog[i];
    lat = 2;
    restart();
    wait_valid(60, ok);
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL irmovq_wait: got 0, want 1");
    else pass_cnt++;
    total_cnt++;
    if ({icode_o, ifun_o, rA_o, rB_o} !== 16'h30F3)
      $display("FAIL irmovq_regs: got %h, want 30f3",
               {icode_o, ifun_o, rA_o, rB_o});
    else pass_cnt++;
    total_cnt++;
    if (valC_o !== 64'hA)
      $display("FAIL irmovq_valc: got %h, want a", valC_o);
    else pass_cnt++;
    total_cnt++;
    if ({pc_o, valP_o, pred_pc_o, stat_o} !==
        {32'd0, 32'd10, 32'd10, 3'd1})
      $display("FAIL irmovq_pcs: got %h %h %h %0d, want 0 a a 1",
               pc_o, valP_o, pred_pc_o, stat_o);
    else pass_cnt++;
    accept();
    wait_valid(40, ok);
    total_cnt++;
    if ({ok, icode_o, rA_o, rB_o, valC_o} !==
        {1'b1, 4'h1, 4'hF, 4'hF, 64'h0})
      $display("FAIL nop_fields: got %b %h %h %h %h, want 1 1 f f 0",
               ok, icode_o, rA_o, rB_o, valC_o);
    else pass_cnt++;
    total_cnt++;
    if ({pc_o, valP_o, pred_pc_o, stat_o} !==
        {32'd10, 32'd11, 32'd11, 3'd1})
      $display("FAIL nop_pcs: got %h %h %h %0d, want a b b 1",
               pc_o, valP_o, pred_pc_o, stat_o);
    else pass_cnt++;
  endtask

  task automatic test_call;
    bit ok;
    logic [31:0] first;
    fill(8'h10);
    mem[0] = 8'h80;
    mem[1] = 8'h40;
    for (int i = 2; i < 9; i++) mem[i] = 8'h00;
    mem[8'h40] = 8'h00;
    lat = 2;
    restart();
    wait_valid(60, ok);
    total_cnt++;
    if ({ok, icode_o, valC_o, pc_o, valP_o, pred_pc_o} !==
        {1'b1, 4'h8, 64'h40, 32'd0, 32'd9, 32'h40})
      $display("FAIL call_fields: got %b %h %h %h %h %h, want 1 8 40 0 9 40",
               ok, icode_o, valC_o, pc_o, valP_o, pred_pc_o);
    else pass_cnt++;
    accept();
    wait_valid(40, ok);
    first = (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF;
    total_cnt++;
    if (first !== 32'h40)
      $display("FAIL call_req_addr: got %h, want 40", first);
    else pass_cnt++;
    total_cnt++;
    if ({ok, pc_o, icode_o, stat_o} !== {1'b1, 32'h40, 4'h0, 3'd2})
      $display("FAIL call_target: got %b %h %h %0d, want 1 40 0 2",
               ok, pc_o, icode_o, stat_o);
    else pass_cnt++;
  endtask

  task automatic test_ret;
    bit ok;
    bit seen;
    fill(8'h10);
    mem[0] = 8'h90;
    lat = 1;
    restart();
    wait_valid(40, ok);
    total_cnt++;
    if ({ok, icode_o, valP_o, pred_pc_o, stat_o} !==
        {1'b1, 4'h9, 32'd1, 32'd1, 3'd1})
      $display("FAIL ret_fields: got %b %h %h %h %0d, want 1 9 1 1 1",
               ok, icode_o, valP_o, pred_pc_o, stat_o);
    else pass_cnt++;
    accept();
    seen = 1'b0;
    repeat (10) begin
      if (inst_valid_o !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total_cnt++;
    if ({seen, req_log.size()} !== {1'b0, 32'd0})
      $display("FAIL ret_stopped: got valid %b reqs %0d, want 0 0",
               seen, req_log.size());
    else pass_cnt++;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h80;
    @(negedge clk);
    redirect_i = 1'b0;
    wait_valid(40, ok);
    total_cnt++;
    if ({ok, pc_o, icode_o, valP_o} !== {1'b1, 32'h80, 4'h1, 32'h81})
      $display("FAIL ret_redirect: got %b %h %h %h, want 1 80 1 81",
               ok, pc_o, icode_o, valP_o);
    else pass_cnt++;
  endtask

  task automatic test_redirect_drop;
    bit ok;
    logic [31:0] second;
    fill(8'h00);
    mem[8'h20] = 8'h20;
    mem[8'h21] = 8'h45;
    lat = 4;
    restart();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_log.size() > 0) break;
    end
    total_cnt++;
    if (req_log.size() !== 1)
      $display("FAIL drop_first_req: got %0d, want 1", req_log.size());
    else pass_cnt++;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h20;
    lat = 1;
    @(negedge clk);
    redirect_i = 1'b0;
    wait_valid(40, ok);
    second = (req_log.size() > 1) ? req_log[1] : 32'hFFFF_FFFF;
    total_cnt++;
    if (second !== 32'h20)
      $display("FAIL drop_new_req: got %h, want 20", second);
    else pass_cnt++;
    total_cnt++;
    if ({ok, icode_o, rA_o, rB_o, pc_o, valP_o, stat_o} !==
        {1'b1, 4'h2, 4'h4, 4'h5, 32'h20, 32'h22, 3'd1})
      $display("FAIL drop_inst: got %b %h %h %h %h %h %0d, want 1 2 4 5 20 22 1",
               ok, icode_o, rA_o, rB_o, pc_o, valP_o, stat_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    fill(8'h10);
    lat = 1;
    restart();
    repeat (20) @(negedge clk);
    total_cnt++;
    if (req_log.size() !== 4)
      $display("FAIL full_reqs: got %0d, want 4", req_log.size());
    else pass_cnt++;
    inst_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if ({inst_valid_o, pc_o, icode_o} !== {1'b1, 32'(i), 4'h1})
        $display("FAIL b2b_%0d: got %b %h %h, want 1 %h 1",
                 i, inst_valid_o, pc_o, icode_o, 32'(i));
      else pass_cnt++;
      @(negedge clk);
    end
    inst_ready_i = 1'b0;
  endtask

  task automatic test_ins;
    bit ok;
    bit seen;
    fill(8'h10);
    mem[0] = 8'hF0;
    lat = 1;
    restart();
    wait_valid(40, ok);
    total_cnt++;
    if ({ok, icode_o, stat_o, pc_o, valP_o} !==
        {1'b1, 4'hF, 3'd4, 32'd0, 32'd1})
      $display("FAIL ins_fields: got %b %h %0d %h %h, want 1 f 4 0 1",
               ok, icode_o, stat_o, pc_o, valP_o);
    else pass_cnt++;
    accept();
    seen = 1'b0;
    repeat (10) begin
      if (inst_valid_o !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total_cnt++;
    if ({seen, req_log.size()} !== {1'b0, 32'd0})
      $display("FAIL ins_stopped: got valid %b reqs %0d, want 0 0",
               seen, req_log.size());
    else pass_cnt++;
  endtask

  task automatic test_adr;
    bit ok;
    bit seen;
    fill(8'h10);
    err_en   = 1'b1;
    err_addr = 32'h0;
    lat = 1;
    restart();
    wait_valid(40, ok);
    total_cnt++;
    if ({ok, stat_o, pc_o, icode_o, valP_o} !==
        {1'b1, 3'd3, 32'd0, 4'h0, 32'd0})
      $display("FAIL adr_fields: got %b %0d %h %h %h, want 1 3 0 0 0",
               ok, stat_o, pc_o, icode_o, valP_o);
    else pass_cnt++;
    accept();
    seen = 1'b0;
    repeat (10) begin
      if (inst_valid_o !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total_cnt++;
    if ({seen, req_log.size()} !== {1'b0, 32'd0})
      $display("FAIL adr_stopped: got valid %b reqs %0d, want 0 0",
               seen, req_log.size());
    else pass_cnt++;
    err_en = 1'b0;
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    rst_n         = 1'b0;
    inst_ready_i  = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    lat           = 1;
    err_en        = 1'b0;
    err_addr      = '0;
    test_reset();
    test_irmovq();
    test_call();
    test_ret();
    test_redirect_drop();
    test_back_to_back();
    test_ins();
    test_adr();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
